dlx_mem_responder: RTL and testbench

- Bus-side memory responder for the DLX core: the target end of the processor's asynchronous-handshake memory bus (AS_N, WR_N, AO, DO in; DI, ACK_N out).
- Decodes each strobe, waits a programmable number of wait states, commits writes or returns read data, and completes with a one-cycle ACK_N pulse.
- Provides a word-addressed synchronous RAM for program and image data.
- Exposes a host load/readback port, usable only while the bus is idle, for preloading programs and image tiles and for dumping results.

---
 rtl/dlx_mem_responder.sv | 142 ++++++++++++++
 tb/tb_dlx_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_responder.sv
// dlx_mem_responder
// Target end of the DLX asynchronous-handshake memory bus, backed by a
// word-addressed synchronous RAM, plus a host load/readback port.
//
// Ports:
//   clk, reset        system clock, async active-low reset
//   AS_N, WR_N        strobe (active low) and direction (0 = write) from core
//   AO, DO            byte address and write data from core
//   DI, ACK_N         read data and one-cycle active-low acknowledge to core
//   ld_we, ld_adr,    host write strobe, word address, write data
//   ld_data
//   ld_q              host readback, one-cycle latency, updates only in IDLE
//   ld_rdy            host port is live (state IDLE)
//   addr_err          sticky: a bus access fell outside the RAM
//
// State table:
//   state   | meaning
//   IDLE    | bus free; host port live; capture a strobe when AS_N=0
//   WAIT    | counting wait states; AS_N=1 aborts back to IDLE
//   ACK     | the next edge performs the access and drives ACK_N low
//   RELEASE | ACK_N back high; wait for the core to drop AS_N
module dlx_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [31:0]       AO,
  input  logic [31:0]       DO,
  output logic [31:0]       DI,
  output logic              ACK_N,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       ld_q,
  output logic              ld_rdy,
  output logic              addr_err
);

  localparam int WAIT_M1 = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_adr;
  logic              lat_wr_n;
  logic [31:0]       lat_do;
  logic              lat_err;

  logic [31:0]       mem [0:(2**ADDR_W)-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [31:0]       mem_wdata;

  // Accesses are word aligned; the byte-lane bits carry no information.
  logic unused_ao;
  assign unused_ao = ^AO[1:0];

  assign ld_rdy = (state == S_IDLE);

  // Host writes (IDLE) and bus writes (ACK) never coincide, so one
  // muxed write port serves both.
  always_comb begin
    mem_we    = 1'b0;
    mem_wadr  = ld_adr;
    mem_wdata = ld_data;
    if (state == S_IDLE && ld_we) begin
      mem_we = 1'b1;
    end else if (state == S_ACK && !lat_wr_n && !lat_err) begin
      mem_we    = 1'b1;
      mem_wadr  = lat_adr;
      mem_wdata = lat_do;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wadr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ACK_N    <= 1'b1;
      DI       <= '0;
      ld_q     <= '0;
      addr_err <= 1'b0;
      lat_adr  <= '0;
      lat_wr_n <= 1'b1;
      lat_do   <= '0;
      lat_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Old contents are returned if the host writes the same word now.
          ld_q <= mem[ld_adr];
          if (!AS_N) begin
            lat_adr  <= AO[ADDR_W+1:2];
            lat_wr_n <= WR_N;
            lat_do   <= DO;
            lat_err  <= (AO[31:ADDR_W+2] != '0);
            cnt      <= 4'(WAIT_M1);
            state    <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (AS_N) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          ACK_N <= 1'b0;
          if (lat_err) begin
            DI       <= '0;
            addr_err <= 1'b1;
          end else if (lat_wr_n) begin
            DI <= mem[lat_adr];
          end
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          ACK_N <= 1'b1;
          if (AS_N) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_responder.sv
module tb_dlx_mem_responder;

  localparam int ADDR_W = 10;
  localparam int W      = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              AS_N;
  logic              WR_N;
  logic [31:0]       AO;
  logic [31:0]       DO;
  logic [31:0]       DI;
  logic              ACK_N;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_adr;
  logic [31:0]       ld_data;
  logic [31:0]       ld_q;
  logic              ld_rdy;
  logic              addr_err;

  always #5 clk = ~clk;

  dlx_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .AS_N     (AS_N),
    .WR_N     (WR_N),
    .AO       (AO),
    .DO       (DO),
    .DI       (DI),
    .ACK_N    (ACK_N),
    .ld_we    (ld_we),
    .ld_adr   (ld_adr),
    .ld_data  (ld_data),
    .ld_q     (ld_q),
    .ld_rdy   (ld_rdy),
    .addr_err (addr_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] di;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: every ACK_N low cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && ACK_N === 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack cyc=%0d DI=%h", cyc, DI);
      end else begin
        e = sb.pop_front();
        if (DI !== e.di || addr_err !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack_resp got DI=%h err=%b cyc=%0d want DI=%h err=%b cyc=%0d",
                   DI, addr_err, cyc, e.di, e.err, e.cyc);
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Drive a strobe; capture happens on the next edge, ACK_N is low in the
  // cycle after capture edge + 1 + W.
  task automatic bus_start(input logic wr, input logic [31:0] ao, input logic [31:0] d,
                           input logic [31:0] exp_di, input logic exp_err);
    exp_t e;
    @(posedge clk);
    #1;
    AS_N = 1'b0;
    WR_N = ~wr;
    AO   = ao;
    DO   = d;
    e.di  = exp_di;
    e.err = exp_err;
    e.cyc = cyc + 2 + W;
    sb.push_back(e);
  endtask

  task automatic bus_finish(input int hold);
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ACK_N === 1'b0) break;
    end
    if (n == 40) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got=none want=ack");
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    AS_N = 1'b1;
    WR_N = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic bus_access(input logic wr, input logic [31:0] ao, input logic [31:0] d,
                            input logic [31:0] exp_di, input logic exp_err, input int hold);
    bus_start(wr, ao, d, exp_di, exp_err);
    bus_finish(hold);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    ld_we = 1'b1; ld_adr = a; ld_data = d;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] want);
    @(posedge clk);
    #1;
    ld_adr = a;
    @(posedge clk);
    #1;
    check32(name, ld_q, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; AS_N = 1'b1; WR_N = 1'b1; AO = '0; DO = '0;
    ld_we = 1'b0; ld_adr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_ack_n", ACK_N, 1'b1);
    check32("rst_di", DI, 32'h0);
    check32("rst_ld_q", ld_q, 32'h0);
    check1("rst_addr_err", addr_err, 1'b0);
    check1("rst_ld_rdy", ld_rdy, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Host preload and core read of word 2
    for (int i = 0; i < 4; i++) host_write(ADDR_W'(i), 32'(i + 1));
    host_write(10'd5, 32'h55);
    host_write(10'd6, 32'h60);
    host_read("host_rd2", 10'd2, 32'd3);
    bus_access(1'b0, 32'h8, 32'h0, 32'd3, 1'b0, 0);

    // Write then read back; write leaves DI alone
    bus_access(1'b1, 32'h10, 32'hDEADBEEF, 32'd3, 1'b0, 0);
    host_read("host_rd4", 10'd4, 32'hDEADBEEF);
    bus_access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Aborted strobe: released before the first WAIT edge
    @(posedge clk);
    #1;
    AS_N = 1'b0; WR_N = 1'b0; AO = 32'h14; DO = 32'hBAD;
    @(posedge clk);
    #1;
    AS_N = 1'b1; WR_N = 1'b1;
    repeat (6) @(posedge clk);
    host_read("abort_nowrite", 10'd5, 32'h55);
    bus_access(1'b0, 32'h14, 32'h0, 32'h55, 1'b0, 0);

    // Held strobe: one ACK only
    bus_access(1'b0, 32'h0, 32'h0, 32'd1, 1'b0, 10);
    bus_access(1'b0, 32'h4, 32'h0, 32'd2, 1'b0, 0);

    // Out of range
    bus_access(1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 0);
    check1("oor_err_set", addr_err, 1'b1);
    bus_access(1'b1, 32'h0001_0000, 32'h99, 32'h0, 1'b1, 0);
    host_read("oor_nowrite", 10'd0, 32'd1);
    bus_access(1'b0, 32'hC, 32'h0, 32'd4, 1'b1, 0);
    check1("oor_err_sticky", addr_err, 1'b1);

    // Host write during WAIT is ignored
    bus_start(1'b0, 32'h4, 32'h0, 32'd2, 1'b1);
    @(posedge clk);
    #1;
    ld_we = 1'b1; ld_adr = 10'd6; ld_data = 32'h666;
    check1("wait_ld_rdy", ld_rdy, 1'b0);
    @(posedge clk);
    #1 ld_we = 1'b0;
    bus_finish(0);
    host_read("wait_ld_ignored", 10'd6, 32'h60);

    // Host write and bus capture on the same IDLE edge
    bus_start(1'b0, 32'h1C, 32'h0, 32'h77, 1'b1);
    ld_we = 1'b1; ld_adr = 10'd7; ld_data = 32'h77;
    @(posedge clk);
    #1 ld_we = 1'b0;
    bus_finish(0);

    // Reset in the middle of a write
    host_write(10'd8, 32'h11111111);
    @(posedge clk);
    #1;
    AS_N = 1'b0; WR_N = 1'b0; AO = 32'h20; DO = 32'h22222222;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check1("midrst_ack_n", ACK_N, 1'b1);
    check32("midrst_di", DI, 32'h0);
    check1("midrst_err", addr_err, 1'b0);
    check1("midrst_idle", ld_rdy, 1'b1);
    check32("midrst_ld_q", ld_q, 32'h0);
    AS_N = 1'b1; WR_N = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    host_read("midrst_nowrite", 10'd8, 32'h11111111);
    bus_access(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

    repeat (5) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_acks got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
